// File: rtl/mem_2r_read_server.sv
// rtl/mem_2r_read_server.sv - dual independent read server with write forwarding and per-channel response FIFOs

// One client channel: 2-entry response FIFO fed from one memory read port.
module mem_2r_channel #(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [depth-1:0] req_addr,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [width-1:0] resp_data,
    output logic [depth-1:0] rd_addr,
    input  logic [width-1:0] mem_out,
    input  logic             wr,
    input  logic [depth-1:0] wr_addr,
    input  logic [width-1:0] wr_data,
    output logic [15:0]      served
);
    logic [width-1:0] slot [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;
    logic [width-1:0] captured;

    // Memory read is combinational, so the address goes straight through.
    assign rd_addr    = req_addr;
    // Readiness only looks at the current fill level; a same-cycle pop does not free a slot.
    assign req_ready  = (count != 2'd2);
    assign resp_valid = (count != 2'd0);
    assign resp_data  = slot[rd_ptr];
    assign push       = req_valid && req_ready;
    assign pop        = resp_valid && resp_ready;
    // A write landing on the requested address this cycle wins over the stale memory word.
    assign captured   = (wr && (wr_addr == req_addr)) ? wr_data : mem_out;

    // FIFO storage, pointers, fill count and served counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
            served  <= 16'd0;
        end else begin
            if (push) begin
                slot[wr_ptr] <= captured;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                served <= served + 16'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// Top: two fully independent channels, each bound to its own memory read port.
module mem_2r_read_server #(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid0,
    output logic             req_ready0,
    input  logic [depth-1:0] req_addr0,
    output logic             resp_valid0,
    input  logic             resp_ready0,
    output logic [width-1:0] resp_data0,
    input  logic             req_valid1,
    output logic             req_ready1,
    input  logic [depth-1:0] req_addr1,
    output logic             resp_valid1,
    input  logic             resp_ready1,
    output logic [width-1:0] resp_data1,
    output logic [depth-1:0] rd_addr0,
    output logic [depth-1:0] rd_addr1,
    input  logic [width-1:0] mem_out0,
    input  logic [width-1:0] mem_out1,
    input  logic             wr,
    input  logic [depth-1:0] wr_addr,
    input  logic [width-1:0] wr_data,
    output logic [15:0]      served0,
    output logic [15:0]      served1
);
    mem_2r_channel #(.width(width), .depth(depth)) u_ch0 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid0),
        .req_ready  (req_ready0),
        .req_addr   (req_addr0),
        .resp_valid (resp_valid0),
        .resp_ready (resp_ready0),
        .resp_data  (resp_data0),
        .rd_addr    (rd_addr0),
        .mem_out    (mem_out0),
        .wr         (wr),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .served     (served0)
    );

    mem_2r_channel #(.width(width), .depth(depth)) u_ch1 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid1),
        .req_ready  (req_ready1),
        .req_addr   (req_addr1),
        .resp_valid (resp_valid1),
        .resp_ready (resp_ready1),
        .resp_data  (resp_data1),
        .rd_addr    (rd_addr1),
        .mem_out    (mem_out1),
        .wr         (wr),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .served     (served1)
    );
endmodule

// File: tb/tb_mem_2r_read_server.sv
// tb/tb_mem_2r_read_server.sv - randomized and directed checks of mem_2r_read_server against a queue model
module tb_mem_2r_read_server;
    localparam int W = 8;
    localparam int D = 4;

    logic         clk;
    logic         rst;
    logic         req_valid0, req_valid1;
    logic         req_ready0, req_ready1;
    logic [D-1:0] req_addr0, req_addr1;
    logic         resp_valid0, resp_valid1;
    logic         resp_ready0, resp_ready1;
    logic [W-1:0] resp_data0, resp_data1;
    logic [D-1:0] rd_addr0, rd_addr1;
    logic [W-1:0] mem_out0, mem_out1;
    logic         wr;
    logic [D-1:0] wr_addr;
    logic [W-1:0] wr_data;
    logic [15:0]  served0, served1;

    int checks = 0;
    int errors = 0;
    bit done = 0;

    logic [W-1:0] mem [1<<D];
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic [15:0]  ms0, ms1;

    mem_2r_read_server #(.width(W), .depth(D)) dut (
        .clk(clk), .rst(rst),
        .req_valid0(req_valid0), .req_ready0(req_ready0), .req_addr0(req_addr0),
        .resp_valid0(resp_valid0), .resp_ready0(resp_ready0), .resp_data0(resp_data0),
        .req_valid1(req_valid1), .req_ready1(req_ready1), .req_addr1(req_addr1),
        .resp_valid1(resp_valid1), .resp_ready1(resp_ready1), .resp_data1(resp_data1),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .mem_out0(mem_out0), .mem_out1(mem_out1),
        .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data),
        .served0(served0), .served1(served1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational memory seen by both read ports; written through the snooped port.
    assign mem_out0 = mem[rd_addr0];
    assign mem_out1 = mem[rd_addr1];

    initial begin
        for (int i = 0; i < (1 << D); i++) mem[i] <= '0;
        mem[1] <= 8'hA1;
        mem[2] <= 8'hB2;
        mem[3] <= 8'h5A;
        mem[7] <= 8'h11;
    end

    always @(posedge clk) begin
        if (wr) mem[wr_addr] <= wr_data;
    end

    // Reference model: each channel is a bounded queue of expected words plus a pop counter.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q0.delete();
            q1.delete();
            ms0 = 16'd0;
            ms1 = 16'd0;
        end else begin
            bit a0, a1, p0, p1;
            logic [W-1:0] d0, d1;
            a0 = req_valid0 && (q0.size() < 2);
            a1 = req_valid1 && (q1.size() < 2);
            p0 = (q0.size() > 0) && resp_ready0;
            p1 = (q1.size() > 0) && resp_ready1;
            d0 = (wr && wr_addr == req_addr0) ? wr_data : mem[req_addr0];
            d1 = (wr && wr_addr == req_addr1) ? wr_data : mem[req_addr1];
            if (p0) begin void'(q0.pop_front()); ms0 = ms0 + 16'd1; end
            if (p1) begin void'(q1.pop_front()); ms1 = ms1 + 16'd1; end
            if (a0) q0.push_back(d0);
            if (a1) q1.push_back(d1);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle, compare all DUT outputs against the model on the inactive edge.
    always @(negedge clk) begin
        if (!done) begin
            chk("req_ready0", {31'd0, req_ready0}, {31'd0, q0.size() < 2});
            chk("req_ready1", {31'd0, req_ready1}, {31'd0, q1.size() < 2});
            chk("resp_valid0", {31'd0, resp_valid0}, {31'd0, q0.size() > 0});
            chk("resp_valid1", {31'd0, resp_valid1}, {31'd0, q1.size() > 0});
            if (q0.size() > 0) chk("resp_data0", {24'd0, resp_data0}, {24'd0, q0[0]});
            if (q1.size() > 0) chk("resp_data1", {24'd0, resp_data1}, {24'd0, q1[0]});
            chk("served0", {16'd0, served0}, {16'd0, ms0});
            chk("served1", {16'd0, served1}, {16'd0, ms1});
            chk("rd_addr0", {28'd0, rd_addr0}, {28'd0, req_addr0});
            chk("rd_addr1", {28'd0, rd_addr1}, {28'd0, req_addr1});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid0 = 0; req_valid1 = 0; resp_ready0 = 0; resp_ready1 = 0;
        wr = 0; wr_addr = '0; wr_data = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 0;
        tick();
        tick();
        rst = 1;
    endtask

    initial begin
        rst = 0;
        idle();
        req_addr0 = '0;
        req_addr1 = '0;
        tick();
        tick();
        chk("rst resp_valid0", {31'd0, resp_valid0}, 32'd0);
        chk("rst resp_valid1", {31'd0, resp_valid1}, 32'd0);
        chk("rst req_ready0", {31'd0, req_ready0}, 32'd1);
        chk("rst req_ready1", {31'd0, req_ready1}, 32'd1);
        chk("rst resp_data0", {24'd0, resp_data0}, 32'd0);
        chk("rst resp_data1", {24'd0, resp_data1}, 32'd0);
        chk("rst served0", {16'd0, served0}, 32'd0);
        rst = 1;

        // Single read with one-cycle latency.
        req_valid0 = 1; req_addr0 = 4'd3; resp_ready0 = 1;
        tick();
        req_valid0 = 0;
        chk("lat resp_valid0", {31'd0, resp_valid0}, 32'd1);
        chk("lat resp_data0", {24'd0, resp_data0}, 32'h5A);
        tick();
        chk("lat served0", {16'd0, served0}, 32'd1);
        chk("lat empty0", {31'd0, resp_valid0}, 32'd0);

        // Back-pressure on channel 1: two accepted, third held, then drained in order.
        do_reset();
        req_valid1 = 1; req_addr1 = 4'd1;
        tick();
        req_addr1 = 4'd2;
        tick();
        chk("full req_ready1", {31'd0, req_ready1}, 32'd0);
        req_addr1 = 4'd3;
        tick();
        chk("held req_ready1", {31'd0, req_ready1}, 32'd0);
        chk("head1 a", {24'd0, resp_data1}, 32'hA1);
        resp_ready1 = 1;
        tick();
        chk("head1 b", {24'd0, resp_data1}, 32'hB2);
        chk("ready1 after pop", {31'd0, req_ready1}, 32'd1);
        tick();
        req_valid1 = 0;
        chk("head1 c", {24'd0, resp_data1}, 32'h5A);
        tick();
        chk("drain valid1", {31'd0, resp_valid1}, 32'd0);
        chk("drain served1", {16'd0, served1}, 32'd3);

        // Write forwarding in the accept cycle.
        do_reset();
        wr = 1; wr_addr = 4'd5; wr_data = 8'hC3;
        req_valid0 = 1; req_addr0 = 4'd5; resp_ready0 = 1;
        tick();
        wr = 0; req_valid0 = 0;
        chk("fwd resp_data0", {24'd0, resp_data0}, 32'hC3);
        tick();

        // Both channels read the same word in the same cycle.
        do_reset();
        req_valid0 = 1; req_addr0 = 4'd7; resp_ready0 = 1;
        req_valid1 = 1; req_addr1 = 4'd7; resp_ready1 = 1;
        tick();
        req_valid0 = 0; req_valid1 = 0;
        chk("same resp_data0", {24'd0, resp_data0}, 32'h11);
        chk("same resp_data1", {24'd0, resp_data1}, 32'h11);
        tick();
        chk("same served0", {16'd0, served0}, 32'd1);
        chk("same served1", {16'd0, served1}, 32'd1);

        // Mid-cycle reset with a full channel 0 FIFO.
        req_valid0 = 1; req_addr0 = 4'd7; resp_ready0 = 0; resp_ready1 = 0;
        tick();
        tick();
        req_valid0 = 0;
        chk("pre-rst ready0", {31'd0, req_ready0}, 32'd0);
        @(negedge clk);
        #2;
        rst = 0;
        #1;
        chk("async resp_valid0", {31'd0, resp_valid0}, 32'd0);
        chk("async req_ready0", {31'd0, req_ready0}, 32'd1);
        chk("async served0", {16'd0, served0}, 32'd0);
        chk("async resp_data0", {24'd0, resp_data0}, 32'd0);
        tick();
        rst = 1;
        resp_ready0 = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no stale valid0", {31'd0, resp_valid0}, 32'd0);
        end

        // Randomized traffic with occasional forwarding hits and rare resets.
        for (int i = 0; i < 3000; i++) begin
            req_valid0  = ($urandom_range(0, 99) < 60);
            req_valid1  = ($urandom_range(0, 99) < 60);
            resp_ready0 = ($urandom_range(0, 99) < 55);
            resp_ready1 = ($urandom_range(0, 99) < 55);
            req_addr0   = D'($urandom);
            req_addr1   = D'($urandom);
            wr          = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 2))
                0:       wr_addr = req_addr0;
                1:       wr_addr = req_addr1;
                default: wr_addr = D'($urandom);
            endcase
            wr_data = W'($urandom);
            if ($urandom_range(0, 599) == 0) rst = 0;
            tick();
            rst = 1;
        end

        // Streaming on channel 0 until the served counter wraps.
        do_reset();
        req_valid0 = 1; resp_ready0 = 1;
        for (int i = 0; i < 70000 && ms0 != 16'hFFFE; i++) begin
            req_addr0 = D'($urandom);
            tick();
        end
        chk("wrap pre served0", {16'd0, served0}, 32'hFFFE);
        tick();
        tick();
        chk("wrap served0", {16'd0, served0}, 32'h0000);

        idle();
        done = 1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
